// File: rtl/rank_pipe_rr.sv
// Rank pipeline front end: per-op input queues feeding rank units, plus a
// round-robin collector that moves unit results into a shared output FIFO.
module rank_pipe_rr #(
  parameter int NUM_OPS           = 3,
  parameter int OP_BITS           = 2,
  parameter int META_WIDTH        = 16,
  parameter int FLOW_ID_WIDTH     = 16,
  parameter int FLOW_WEIGHT_WIDTH = 8,
  parameter int RANK_WIDTH        = 16,
  parameter int Q_DEPTH_BITS      = 2,
  parameter int OUT_DEPTH_BITS    = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   insert,
  input  logic [OP_BITS-1:0]                     rank_op_in,
  input  logic [META_WIDTH-1:0]                  meta_in,
  input  logic [FLOW_ID_WIDTH-1:0]               flowID_in,
  input  logic [FLOW_WEIGHT_WIDTH-1:0]           flow_weight_in,
  output logic [NUM_OPS-1:0]                     op_busy,
  input  logic                                   remove,
  output logic                                   valid_out,
  output logic [RANK_WIDTH-1:0]                  rank_out,
  output logic [META_WIDTH-1:0]                  meta_out,
  output logic [15:0]                            drop_count,
  output logic [NUM_OPS-1:0]                     unit_insert,
  output logic [NUM_OPS*META_WIDTH-1:0]          unit_meta_in,
  output logic [NUM_OPS*FLOW_ID_WIDTH-1:0]       unit_flowID_in,
  output logic [NUM_OPS*FLOW_WEIGHT_WIDTH-1:0]   unit_flow_weight_in,
  input  logic [NUM_OPS-1:0]                     unit_busy,
  input  logic [NUM_OPS-1:0]                     unit_valid,
  output logic [NUM_OPS-1:0]                     unit_remove,
  input  logic [NUM_OPS*RANK_WIDTH-1:0]          unit_rank_out,
  input  logic [NUM_OPS*META_WIDTH-1:0]          unit_meta_out
);

  localparam int QD = 1 << Q_DEPTH_BITS;
  localparam int OD = 1 << OUT_DEPTH_BITS;
  localparam int EW = META_WIDTH + FLOW_ID_WIDTH + FLOW_WEIGHT_WIDTH;
  localparam int OW = RANK_WIDTH + META_WIDTH;
  localparam int GW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

  logic [EW-1:0]             qMem_q [NUM_OPS][QD];
  logic [Q_DEPTH_BITS-1:0]   qWr_q  [NUM_OPS];
  logic [Q_DEPTH_BITS-1:0]   qWr_d  [NUM_OPS];
  logic [Q_DEPTH_BITS-1:0]   qRd_q  [NUM_OPS];
  logic [Q_DEPTH_BITS-1:0]   qRd_d  [NUM_OPS];
  logic [Q_DEPTH_BITS:0]     qCnt_q [NUM_OPS];
  logic [Q_DEPTH_BITS:0]     qCnt_d [NUM_OPS];
  logic [NUM_OPS-1:0]        qFull, qPush, qPop;

  logic [OW-1:0]             outMem_q [OD];
  logic [OUT_DEPTH_BITS-1:0] outWr_q, outWr_d, outRd_q, outRd_d;
  logic [OUT_DEPTH_BITS:0]   outCnt_q, outCnt_d;
  logic                      outFull, outPop;
  logic [OW-1:0]             outHead, outWrData;

  logic [GW-1:0]             lastGrant_q, lastGrant_d, grantIdx, candIdx;
  logic                      grantValid;
  int                        cand;
  logic [15:0]               drop_q, drop_d;
  logic                      dropInc;

  // Input queues: full is judged before any same-cycle pop, so a pop never
  // makes room for a push in the same cycle.
  always_comb begin
    for (int k = 0; k < NUM_OPS; k++) begin
      qFull[k]  = (qCnt_q[k] == (Q_DEPTH_BITS+1)'(QD));
      qPush[k]  = !rst && insert && (rank_op_in == OP_BITS'(k)) && !qFull[k];
      qPop[k]   = !rst && (qCnt_q[k] != '0) && !unit_busy[k];
      qWr_d[k]  = qWr_q[k] + Q_DEPTH_BITS'(qPush[k]);
      qRd_d[k]  = qRd_q[k] + Q_DEPTH_BITS'(qPop[k]);
      qCnt_d[k] = qCnt_q[k] + (Q_DEPTH_BITS+1)'(qPush[k]) - (Q_DEPTH_BITS+1)'(qPop[k]);
    end
  end

  always_comb begin
    unit_meta_in        = '0;
    unit_flowID_in      = '0;
    unit_flow_weight_in = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      if (qPop[k]) begin
        {unit_meta_in[k*META_WIDTH +: META_WIDTH],
         unit_flowID_in[k*FLOW_ID_WIDTH +: FLOW_ID_WIDTH],
         unit_flow_weight_in[k*FLOW_WEIGHT_WIDTH +: FLOW_WEIGHT_WIDTH]} = qMem_q[k][qRd_q[k]];
      end
    end
  end

  assign unit_insert = qPop;
  assign op_busy     = qFull;

  // An insert that no queue accepted (bad op or full target) is a drop.
  assign dropInc = !rst && insert && (qPush == '0);
  assign drop_d  = (dropInc && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
  assign drop_count = drop_q;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    cand       = 0;
    candIdx    = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      cand    = (int'(lastGrant_q) + 1 + i) % NUM_OPS;
      candIdx = GW'(cand);
      if (!grantValid && unit_valid[candIdx]) begin
        grantValid = 1'b1;
        grantIdx   = candIdx;
      end
    end
    if (rst || outFull) grantValid = 1'b0;
  end

  assign unit_remove = grantValid ? (NUM_OPS'(1) << grantIdx) : '0;
  assign lastGrant_d = grantValid ? grantIdx : lastGrant_q;
  assign outWrData   = {unit_rank_out[grantIdx*RANK_WIDTH +: RANK_WIDTH],
                        unit_meta_out[grantIdx*META_WIDTH +: META_WIDTH]};

  assign outFull  = (outCnt_q == (OUT_DEPTH_BITS+1)'(OD));
  assign outPop   = !rst && remove && (outCnt_q != '0);
  assign outWr_d  = outWr_q + OUT_DEPTH_BITS'(grantValid);
  assign outRd_d  = outRd_q + OUT_DEPTH_BITS'(outPop);
  assign outCnt_d = outCnt_q + (OUT_DEPTH_BITS+1)'(grantValid) - (OUT_DEPTH_BITS+1)'(outPop);

  assign outHead   = outMem_q[outRd_q];
  assign valid_out = (outCnt_q != '0);
  assign rank_out  = outHead[OW-1:META_WIDTH];
  assign meta_out  = outHead[META_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_OPS; k++) begin
        qWr_q[k]  <= '0;
        qRd_q[k]  <= '0;
        qCnt_q[k] <= '0;
        for (int e = 0; e < QD; e++) qMem_q[k][e] <= '0;
      end
      for (int e = 0; e < OD; e++) outMem_q[e] <= '0;
      outWr_q     <= '0;
      outRd_q     <= '0;
      outCnt_q    <= '0;
      lastGrant_q <= GW'(NUM_OPS - 1);
      drop_q      <= '0;
    end else begin
      for (int k = 0; k < NUM_OPS; k++) begin
        if (qPush[k]) qMem_q[k][qWr_q[k]] <= {meta_in, flowID_in, flow_weight_in};
        qWr_q[k]  <= qWr_d[k];
        qRd_q[k]  <= qRd_d[k];
        qCnt_q[k] <= qCnt_d[k];
      end
      if (grantValid) outMem_q[outWr_q] <= outWrData;
      outWr_q     <= outWr_d;
      outRd_q     <= outRd_d;
      outCnt_q    <= outCnt_d;
      lastGrant_q <= lastGrant_d;
      drop_q      <= drop_d;
    end
  end

endmodule

// File: tb/tb_rank_pipe_rr.sv
// Scoreboard bench for rank_pipe_rr: queue forwarding, drops, round-robin
// collection into the output FIFO, FIFO-full stall and mid-run reset.
module tb_rank_pipe_rr;

  localparam int N  = 3;
  localparam int MW = 16;
  localparam int FW = 16;
  localparam int WW = 8;
  localparam int RW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            insert = 1'b0;
  logic [1:0]      rank_op_in = '0;
  logic [MW-1:0]   meta_in = '0;
  logic [FW-1:0]   flowID_in = '0;
  logic [WW-1:0]   flow_weight_in = '0;
  logic [N-1:0]    op_busy;
  logic            remove = 1'b0;
  logic            valid_out;
  logic [RW-1:0]   rank_out;
  logic [MW-1:0]   meta_out;
  logic [15:0]     drop_count;
  logic [N-1:0]    unit_insert;
  logic [N*MW-1:0] unit_meta_in;
  logic [N*FW-1:0] unit_flowID_in;
  logic [N*WW-1:0] unit_flow_weight_in;
  logic [N-1:0]    unit_busy = '0;
  logic [N-1:0]    unit_valid = '0;
  logic [N-1:0]    unit_remove;
  logic [N*RW-1:0] unit_rank_out = '0;
  logic [N*MW-1:0] unit_meta_out = '0;

  int checks = 0;
  int errors = 0;
  logic [MW-1:0]    qSb[$];
  logic [RW+MW-1:0] outSb[$];
  logic [RW+MW-1:0] exp;
  logic [MW-1:0]    expMeta;

  rank_pipe_rr dut (
    .clk(clk), .rst(rst), .insert(insert), .rank_op_in(rank_op_in),
    .meta_in(meta_in), .flowID_in(flowID_in), .flow_weight_in(flow_weight_in),
    .op_busy(op_busy), .remove(remove), .valid_out(valid_out),
    .rank_out(rank_out), .meta_out(meta_out), .drop_count(drop_count),
    .unit_insert(unit_insert), .unit_meta_in(unit_meta_in),
    .unit_flowID_in(unit_flowID_in), .unit_flow_weight_in(unit_flow_weight_in),
    .unit_busy(unit_busy), .unit_valid(unit_valid), .unit_remove(unit_remove),
    .unit_rank_out(unit_rank_out), .unit_meta_out(unit_meta_out)
  );

  always #5 clk = ~clk;

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    unit_valid = 3'b111;
    @(negedge clk);
    #1;
    checks++;
    if (unit_remove !== 3'b000) begin errors++; $display("FAIL reset_remove got %b exp 000", unit_remove); end
    @(negedge clk);
    rst = 1'b0;
    unit_valid = '0;
    #1;
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_out); end
    checks++;
    if (op_busy !== 3'b000) begin errors++; $display("FAIL reset_busy got %b exp 000", op_busy); end
    checks++;
    if (rank_out !== 16'h0 || meta_out !== 16'h0) begin errors++; $display("FAIL reset_head got %h/%h exp 0/0", rank_out, meta_out); end
    checks++;
    if (drop_count !== 16'h0) begin errors++; $display("FAIL reset_drop got %h exp 0", drop_count); end
  endtask

  task automatic test_forward();
    @(negedge clk);
    insert = 1'b1; rank_op_in = 2'd1; meta_in = 16'h00AA; flowID_in = 16'h1234; flow_weight_in = 8'h5A;
    #1;
    checks++;
    if (unit_insert !== 3'b000) begin errors++; $display("FAIL fwd_early got %b exp 000", unit_insert); end
    @(negedge clk);
    insert = 1'b0;
    #1;
    checks++;
    if (unit_insert !== 3'b010) begin errors++; $display("FAIL fwd_strobe got %b exp 010", unit_insert); end
    checks++;
    if (unit_meta_in[MW +: MW] !== 16'h00AA || unit_flowID_in[FW +: FW] !== 16'h1234 || unit_flow_weight_in[WW +: WW] !== 8'h5A) begin
      errors++; $display("FAIL fwd_data got %h/%h/%h exp 00aa/1234/5a", unit_meta_in[MW +: MW], unit_flowID_in[FW +: FW], unit_flow_weight_in[WW +: WW]);
    end
    checks++;
    if (unit_meta_in[0 +: MW] !== 16'h0 || unit_meta_in[2*MW +: MW] !== 16'h0) begin
      errors++; $display("FAIL fwd_idle_slices got %h/%h exp 0/0", unit_meta_in[0 +: MW], unit_meta_in[2*MW +: MW]);
    end
    @(negedge clk);
    #1;
    checks++;
    if (unit_insert !== 3'b000) begin errors++; $display("FAIL fwd_popped got %b exp 000", unit_insert); end
  endtask

  task automatic test_queue_full();
    unit_busy = 3'b001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) begin
        #1;
        checks++;
        if (op_busy !== 3'b001) begin errors++; $display("FAIL full_busy got %b exp 001", op_busy); end
        checks++;
        if (drop_count !== 16'd0) begin errors++; $display("FAIL full_nodrop got %0d exp 0", drop_count); end
      end
      insert = 1'b1; rank_op_in = 2'd0; meta_in = 16'h0010 + 16'(i);
      flowID_in = 16'(i); flow_weight_in = 8'(i);
      if (i < 4) qSb.push_back(meta_in);
    end
    @(negedge clk);
    insert = 1'b1; rank_op_in = 2'd2; meta_in = 16'h0055;
    #1;
    checks++;
    if (drop_count !== 16'd1) begin errors++; $display("FAIL full_drop got %0d exp 1", drop_count); end
    checks++;
    if (unit_insert !== 3'b000) begin errors++; $display("FAIL full_held got %b exp 000", unit_insert); end
    @(negedge clk);
    insert = 1'b0;
    #1;
    checks++;
    if (unit_insert !== 3'b100 || unit_meta_in[2*MW +: MW] !== 16'h0055) begin
      errors++; $display("FAIL full_other_op got %b/%h exp 100/0055", unit_insert, unit_meta_in[2*MW +: MW]);
    end
    // Release op0 while its queue is still full: the same-cycle insert is dropped.
    @(negedge clk);
    unit_busy = 3'b000;
    insert = 1'b1; rank_op_in = 2'd0; meta_in = 16'h0020;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        meta_in = 16'h0021;
        qSb.push_back(16'h0021);
      end
      if (i == 2) insert = 1'b0;
      #1;
      expMeta = qSb.pop_front();
      checks++;
      if (unit_insert !== 3'b001 || unit_meta_in[0 +: MW] !== expMeta) begin
        errors++; $display("FAIL drain_op0 step %0d got %b/%h exp 001/%h", i, unit_insert, unit_meta_in[0 +: MW], expMeta);
      end
      if (i == 2) begin
        checks++;
        if (drop_count !== 16'd2) begin errors++; $display("FAIL drop_while_full got %0d exp 2", drop_count); end
        checks++;
        if (op_busy !== 3'b000) begin errors++; $display("FAIL pushpop_busy got %b exp 000", op_busy); end
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (unit_insert !== 3'b000) begin errors++; $display("FAIL drain_empty got %b exp 000", unit_insert); end
  endtask

  task automatic test_bad_op();
    @(negedge clk);
    insert = 1'b1; rank_op_in = 2'd3; meta_in = 16'h0077;
    @(negedge clk);
    insert = 1'b0;
    #1;
    checks++;
    if (drop_count !== 16'd3) begin errors++; $display("FAIL badop_drop got %0d exp 3", drop_count); end
    checks++;
    if (unit_insert !== 3'b000 || op_busy !== 3'b000) begin
      errors++; $display("FAIL badop_queues got %b/%b exp 000/000", unit_insert, op_busy);
    end
  endtask

  task automatic test_round_robin();
    pulse_reset();
    unit_rank_out = {16'h1002, 16'h1001, 16'h1000};
    unit_meta_out = {16'h2002, 16'h2001, 16'h2000};
    unit_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (unit_remove !== (3'b001 << (i % 3))) begin
        errors++; $display("FAIL rr_grant %0d got %b exp %b", i, unit_remove, 3'b001 << (i % 3));
      end
      outSb.push_back({16'h1000 + 16'(i % 3), 16'h2000 + 16'(i % 3)});
      if (i < 2) begin
        checks++;
        if (valid_out !== (i == 1)) begin errors++; $display("FAIL rr_latency %0d got %b exp %b", i, valid_out, i == 1); end
      end
      @(negedge clk);
    end
    unit_valid = '0;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp = outSb.pop_front();
      checks++;
      if (valid_out !== 1'b1 || {rank_out, meta_out} !== exp) begin
        errors++; $display("FAIL rr_out %0d got %b/%h exp 1/%h", i, valid_out, {rank_out, meta_out}, exp);
      end
      remove = 1'b1;
      @(negedge clk);
    end
    remove = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL rr_empty got %b exp 0", valid_out); end
  endtask

  task automatic test_out_full();
    pulse_reset();
    unit_valid = 3'b100;
    for (int i = 0; i < 16; i++) begin
      unit_rank_out[2*RW +: RW] = 16'h3000 + 16'(i);
      unit_meta_out[2*MW +: MW] = 16'h4000 + 16'(i);
      #1;
      checks++;
      if (unit_remove !== 3'b100) begin errors++; $display("FAIL fill_grant %0d got %b exp 100", i, unit_remove); end
      outSb.push_back({16'h3000 + 16'(i), 16'h4000 + 16'(i)});
      @(negedge clk);
    end
    unit_rank_out[2*RW +: RW] = 16'h3100;
    unit_meta_out[2*MW +: MW] = 16'h4100;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (unit_remove !== 3'b000) begin errors++; $display("FAIL full_stall %0d got %b exp 000", i, unit_remove); end
      @(negedge clk);
    end
    remove = 1'b1;
    #1;
    checks++;
    if (unit_remove !== 3'b000) begin errors++; $display("FAIL full_remove_stall got %b exp 000", unit_remove); end
    exp = outSb.pop_front();
    checks++;
    if ({rank_out, meta_out} !== exp) begin errors++; $display("FAIL full_head got %h exp %h", {rank_out, meta_out}, exp); end
    @(negedge clk);
    remove = 1'b0;
    #1;
    checks++;
    if (unit_remove !== 3'b100) begin errors++; $display("FAIL one_grant got %b exp 100", unit_remove); end
    outSb.push_back({16'h3100, 16'h4100});
    @(negedge clk);
    #1;
    checks++;
    if (unit_remove !== 3'b000) begin errors++; $display("FAIL refull_stall got %b exp 000", unit_remove); end
    unit_valid = '0;
    for (int i = 0; i < 16; i++) begin
      #1;
      exp = outSb.pop_front();
      checks++;
      if (valid_out !== 1'b1 || {rank_out, meta_out} !== exp) begin
        errors++; $display("FAIL full_drain %0d got %b/%h exp 1/%h", i, valid_out, {rank_out, meta_out}, exp);
      end
      remove = 1'b1;
      @(negedge clk);
    end
    remove = 1'b0;
  endtask

  task automatic test_reset_mid();
    unit_busy = 3'b111;
    unit_rank_out = {16'h5002, 16'h5001, 16'h5000};
    unit_meta_out = {16'h6002, 16'h6001, 16'h6000};
    for (int i = 0; i < 5; i++) begin
      unit_valid = 3'b001;
      insert = (i < 4);
      rank_op_in = 2'(i);
      meta_in = 16'h0700 + 16'(i);
      @(negedge clk);
    end
    insert = 1'b0; unit_valid = '0;
    #1;
    checks++;
    if (drop_count !== 16'd1 || valid_out !== 1'b1) begin
      errors++; $display("FAIL mid_setup got %0d/%b exp 1/1", drop_count, valid_out);
    end
    rst = 1'b1; unit_busy = '0; unit_valid = 3'b111;
    insert = 1'b1; rank_op_in = 2'd0; remove = 1'b1;
    #1;
    checks++;
    if (unit_insert !== 3'b000 || unit_remove !== 3'b000) begin
      errors++; $display("FAIL mid_rst_strobes got %b/%b exp 000/000", unit_insert, unit_remove);
    end
    @(negedge clk);
    rst = 1'b0; insert = 1'b0; remove = 1'b0; unit_valid = '0;
    outSb.delete();
    #1;
    checks++;
    if (valid_out !== 1'b0 || op_busy !== 3'b000 || drop_count !== 16'd0) begin
      errors++; $display("FAIL mid_after got %b/%b/%0d exp 0/000/0", valid_out, op_busy, drop_count);
    end
    checks++;
    if (unit_insert !== 3'b000 || unit_remove !== 3'b000 || rank_out !== 16'h0 || meta_out !== 16'h0) begin
      errors++; $display("FAIL mid_idle got %b/%b/%h/%h exp 000/000/0/0", unit_insert, unit_remove, rank_out, meta_out);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_queue_full();
    test_bad_op();
    test_round_robin();
    test_out_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
